// File: rtl/multi_timer_core.sv
`default_nettype none
// ============================================================================
// Module   : multi_timer_core
// Purpose  : N_CH independent hh:mm:ss.xx channels (stopwatch / countdown)
//            sharing one sub-second tick divider; ch_sel picks the channel.
// Revision : 1.0 - initial release
// ============================================================================
module multi_timer_core #(
    parameter int  CLK_HZ   = 100_000_000,
    parameter int  TICK_HZ  = 100,
    parameter int  N_CH     = 4,
    parameter int  HOUR_MAX = 24,
    localparam int SEL_W    = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] ch_sel,
    input  logic             i_runstop,
    input  logic             i_clear,
    input  logic             i_mode,
    input  logic [1:0]       i_field,
    input  logic             i_up,
    input  logic             i_down,
    output logic [6:0]       msec,
    output logic [5:0]       sec,
    output logic [5:0]       min,
    output logic [4:0]       hour,
    output logic [N_CH-1:0]  o_run,
    output logic [N_CH-1:0]  o_dir,
    output logic [N_CH-1:0]  o_done,
    output logic             o_tick
);

    localparam int              C_DIV      = CLK_HZ / TICK_HZ;
    localparam int              C_DIV_W    = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(C_DIV - 1);
    localparam logic [6:0]      C_MS_LAST  = 7'(TICK_HZ - 1);
    localparam logic [5:0]      C_SM_LAST  = 6'd59;
    localparam logic [4:0]      C_HR_LAST  = 5'(HOUR_MAX - 1);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [C_DIV_W-1:0] r_div;
    logic               w_tick;

    state_t      r_state   [N_CH];
    state_t      w_state_nx[N_CH];
    logic [6:0]  r_ms      [N_CH];
    logic [6:0]  w_ms_nx   [N_CH];
    logic [5:0]  r_sec     [N_CH];
    logic [5:0]  w_sec_nx  [N_CH];
    logic [5:0]  r_min     [N_CH];
    logic [5:0]  w_min_nx  [N_CH];
    logic [4:0]  r_hr      [N_CH];
    logic [4:0]  w_hr_nx   [N_CH];
    logic [N_CH-1:0] r_dir, w_dir_nx, r_done, w_done_nx;

    logic [6:0] r_disp_ms;
    logic [5:0] r_disp_sec;
    logic [5:0] r_disp_min;
    logic [4:0] r_disp_hr;

    function automatic logic [5:0] f_step60(input logic [5:0] v, input logic inc);
        if (inc) return (v == C_SM_LAST) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? C_SM_LAST : v - 6'd1;
    endfunction

    function automatic logic [4:0] f_step_hr(input logic [4:0] v, input logic inc);
        if (inc) return (v == C_HR_LAST) ? 5'd0 : v + 5'd1;
        return (v == 5'd0) ? C_HR_LAST : v - 5'd1;
    endfunction

    // Free-running divider; the tick is the wrap cycle itself.
    always_comb w_tick = (r_div == C_DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + C_DIV_W'(1);
        end
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_state_nx[c] = r_state[c];
            w_dir_nx[c]   = r_dir[c];
            w_done_nx[c]  = 1'b0;
            w_ms_nx[c]    = r_ms[c];
            w_sec_nx[c]   = r_sec[c];
            w_min_nx[c]   = r_min[c];
            w_hr_nx[c]    = r_hr[c];

            // Tick advance uses the pre-command state; commands overlay it.
            if (r_state[c] == ST_RUN && w_tick) begin
                if (!r_dir[c]) begin
                    if (r_ms[c] == C_MS_LAST) begin
                        w_ms_nx[c] = 7'd0;
                        if (r_sec[c] == C_SM_LAST) begin
                            w_sec_nx[c] = 6'd0;
                            if (r_min[c] == C_SM_LAST) begin
                                w_min_nx[c] = 6'd0;
                                w_hr_nx[c]  = f_step_hr(r_hr[c], 1'b1);
                            end else begin
                                w_min_nx[c] = r_min[c] + 6'd1;
                            end
                        end else begin
                            w_sec_nx[c] = r_sec[c] + 6'd1;
                        end
                    end else begin
                        w_ms_nx[c] = r_ms[c] + 7'd1;
                    end
                end else begin
                    if (r_ms[c] == 7'd0) begin
                        w_ms_nx[c] = C_MS_LAST;
                        if (r_sec[c] == 6'd0) begin
                            w_sec_nx[c] = C_SM_LAST;
                            if (r_min[c] == 6'd0) begin
                                w_min_nx[c] = C_SM_LAST;
                                w_hr_nx[c]  = r_hr[c] - 5'd1;
                            end else begin
                                w_min_nx[c] = r_min[c] - 6'd1;
                            end
                        end else begin
                            w_sec_nx[c] = r_sec[c] - 6'd1;
                        end
                    end else begin
                        w_ms_nx[c] = r_ms[c] - 7'd1;
                    end
                    if ({w_ms_nx[c], w_sec_nx[c], w_min_nx[c], w_hr_nx[c]} == '0) begin
                        w_state_nx[c] = ST_STOP;
                        w_done_nx[c]  = 1'b1;
                    end
                end
            end

            if (ch_sel == SEL_W'(c)) begin
                if (i_clear) begin
                    w_state_nx[c] = ST_STOP;
                    w_done_nx[c]  = 1'b0;
                    w_ms_nx[c]    = 7'd0;
                    w_sec_nx[c]   = 6'd0;
                    w_min_nx[c]   = 6'd0;
                    w_hr_nx[c]    = 5'd0;
                end else if (i_runstop) begin
                    if (r_state[c] == ST_RUN) begin
                        w_state_nx[c] = ST_STOP;
                    end else if (!(r_dir[c] &&
                                 {r_ms[c], r_sec[c], r_min[c], r_hr[c]} == '0)) begin
                        w_state_nx[c] = ST_RUN;
                    end
                end else if (r_state[c] == ST_STOP) begin
                    if (i_mode) begin
                        w_dir_nx[c] = ~r_dir[c];
                    end else if (i_up || i_down) begin
                        case (i_field)
                            2'd0: begin
                                w_sec_nx[c] = f_step60(r_sec[c], i_up);
                                w_ms_nx[c]  = 7'd0;
                            end
                            2'd1: begin
                                w_min_nx[c] = f_step60(r_min[c], i_up);
                                w_ms_nx[c]  = 7'd0;
                            end
                            2'd2: begin
                                w_hr_nx[c] = f_step_hr(r_hr[c], i_up);
                                w_ms_nx[c] = 7'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                r_state[c] <= ST_STOP;
                r_ms[c]    <= '0;
                r_sec[c]   <= '0;
                r_min[c]   <= '0;
                r_hr[c]    <= '0;
            end
            r_dir      <= '0;
            r_done     <= '0;
            r_disp_ms  <= '0;
            r_disp_sec <= '0;
            r_disp_min <= '0;
            r_disp_hr  <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                r_state[c] <= w_state_nx[c];
                r_ms[c]    <= w_ms_nx[c];
                r_sec[c]   <= w_sec_nx[c];
                r_min[c]   <= w_min_nx[c];
                r_hr[c]    <= w_hr_nx[c];
            end
            r_dir      <= w_dir_nx;
            r_done     <= w_done_nx;
            r_disp_ms  <= r_ms[ch_sel];
            r_disp_sec <= r_sec[ch_sel];
            r_disp_min <= r_min[ch_sel];
            r_disp_hr  <= r_hr[ch_sel];
        end
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            o_run[c] = (r_state[c] == ST_RUN);
        end
    end

    assign o_dir  = r_dir;
    assign o_done = r_done;
    assign o_tick = w_tick;
    assign msec   = r_disp_ms;
    assign sec    = r_disp_sec;
    assign min    = r_disp_min;
    assign hour   = r_disp_hr;

endmodule
`default_nettype wire

// File: tb/tb_multi_timer_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_timer_core
// Purpose  : Self-checking bench; reference keeps each channel as a single
//            sub-second total and derives fields arithmetically.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_timer_core;

    localparam int TH   = 100;
    localparam int HM   = 24;
    localparam int DIV  = 10;
    localparam int MAXT = HM * 3600 * TH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ch_sel = '0;
    logic       i_runstop = 1'b0, i_clear = 1'b0, i_mode = 1'b0;
    logic [1:0] i_field = '0;
    logic       i_up = 1'b0, i_down = 1'b0;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [3:0] o_run, o_dir, o_done;
    logic       o_tick;

    multi_timer_core #(
        .CLK_HZ  (1000),
        .TICK_HZ (TH),
        .N_CH    (4),
        .HOUR_MAX(HM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_sel   (ch_sel),
        .i_runstop(i_runstop),
        .i_clear  (i_clear),
        .i_mode   (i_mode),
        .i_field  (i_field),
        .i_up     (i_up),
        .i_down   (i_down),
        .msec     (msec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .o_run    (o_run),
        .o_dir    (o_dir),
        .o_done   (o_done),
        .o_tick   (o_tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int   m_t   [4];
    bit   m_run [4];
    bit   m_dir [4];
    bit   m_done[4];
    int   cyc;
    int   e_ms, e_s, e_m, e_h;
    logic [3:0] e_run, e_dir, e_done;
    logic e_tick;
    logic [23:0] e_disp;

    function automatic int f_edit(int t, int fld, int d);
        int h, m, s;
        h = t / (3600 * TH);
        m = (t / (60 * TH)) % 60;
        s = (t / TH) % 60;
        case (fld)
            0: s = (s + d + 60) % 60;
            1: m = (m + d + 60) % 60;
            2: h = (h + d + HM) % HM;
            default: return t;
        endcase
        return ((h * 60 + m) * 60 + s) * TH;
    endfunction

    // One clock: capture inputs, let the edge happen, advance the reference.
    task automatic cycle();
        bit r, cl, rs, md, up, dn, tk, pre_run;
        int sel, fld, pre_t;
        r = rst; cl = i_clear; rs = i_runstop; md = i_mode; up = i_up; dn = i_down;
        sel = int'(ch_sel); fld = int'(i_field);
        @(posedge clk);
        if (r) begin
            cyc = 0;
            for (int c = 0; c < 4; c++) begin
                m_t[c] = 0; m_run[c] = 0; m_dir[c] = 0; m_done[c] = 0;
            end
            e_ms = 0; e_s = 0; e_m = 0; e_h = 0;
        end else begin
            e_ms = m_t[sel] % TH;
            e_s  = (m_t[sel] / TH) % 60;
            e_m  = (m_t[sel] / (60 * TH)) % 60;
            e_h  = m_t[sel] / (3600 * TH);
            tk = ((cyc % DIV) == DIV - 1);
            cyc++;
            pre_run = m_run[sel];
            pre_t   = m_t[sel];
            for (int c = 0; c < 4; c++) begin
                m_done[c] = 0;
                if (tk && m_run[c]) begin
                    if (!m_dir[c]) begin
                        m_t[c] = (m_t[c] + 1) % MAXT;
                    end else begin
                        m_t[c] = m_t[c] - 1;
                        if (m_t[c] == 0) begin
                            m_run[c] = 0; m_done[c] = 1;
                        end
                    end
                end
            end
            if (cl) begin
                m_t[sel] = 0; m_run[sel] = 0; m_done[sel] = 0;
            end else if (rs) begin
                if (pre_run) m_run[sel] = 0;
                else if (!(m_dir[sel] && pre_t == 0)) m_run[sel] = 1;
            end else if (!pre_run) begin
                if (md) m_dir[sel] = !m_dir[sel];
                else if (up) m_t[sel] = f_edit(m_t[sel], fld, 1);
                else if (dn) m_t[sel] = f_edit(m_t[sel], fld, -1);
            end
        end
        e_tick = ((cyc % DIV) == DIV - 1);
        for (int c = 0; c < 4; c++) begin
            e_run[c] = m_run[c]; e_dir[c] = m_dir[c]; e_done[c] = m_done[c];
        end
        e_disp = {5'(e_h), 6'(e_m), 6'(e_s), 7'(e_ms)};
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    // kind: 0 runstop, 1 clear, 2 mode, 3 up, 4 down
    task automatic pulse(input int kind);
        case (kind)
            0: i_runstop = 1'b1;
            1: i_clear   = 1'b1;
            2: i_mode    = 1'b1;
            3: i_up      = 1'b1;
            default: i_down = 1'b1;
        endcase
        cycle();
        {i_runstop, i_clear, i_mode, i_up, i_down} = '0;
    endtask

    task automatic test_reset();
        int nt;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        n_cmp++;
        if ({hour, min, sec, msec} !== 24'd0) begin
            n_err++; $display("FAIL reset_time: got %h want 0", {hour, min, sec, msec});
        end
        n_cmp++;
        if ({o_run, o_dir, o_done, o_tick} !== 13'd0) begin
            n_err++; $display("FAIL reset_flags: got %h want 0", {o_run, o_dir, o_done, o_tick});
        end
        nt = 0;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            if (o_tick) nt++;
            n_cmp++;
            if (o_tick !== ((k % DIV) == DIV - 1)) begin
                n_err++; $display("FAIL tick_period k=%0d: got %b want %b", k, o_tick, (k % DIV) == DIV - 1);
            end
        end
        n_cmp++;
        if (nt != 3) begin
            n_err++; $display("FAIL tick_count: got %0d want 3", nt);
        end
    endtask

    task automatic test_count_up();
        int lim;
        ch_sel = 2'd0;
        pulse(0);
        lim = 0;
        while (m_t[0] != TH && lim < 1200) begin cycle(); lim++; end
        cycle();
        n_cmp++;
        if (lim >= 1200 || sec !== 6'd1 || msec !== 7'd0) begin
            n_err++; $display("FAIL up_100_ticks: got sec=%0d msec=%0d want sec=1 msec=0", sec, msec);
        end
        pulse(0);
        pulse(1);
        i_field = 2'd2; pulse(4);
        i_field = 2'd1; pulse(4);
        i_field = 2'd0; pulse(4);
        cycle();
        n_cmp++;
        if ({hour, min, sec, msec} !== {5'd23, 6'd59, 6'd59, 7'd0}) begin
            n_err++; $display("FAIL preload: got %0d:%0d:%0d.%0d want 23:59:59.0", hour, min, sec, msec);
        end
        pulse(0);
        lim = 0;
        while (m_t[0] != MAXT - 1 && lim < 1200) begin cycle(); lim++; end
        cycle();
        n_cmp++;
        if (lim >= 1200 || {hour, min, sec, msec} !== {5'd23, 6'd59, 6'd59, 7'd99}) begin
            n_err++; $display("FAIL pre_wrap: got %0d:%0d:%0d.%0d want 23:59:59.99", hour, min, sec, msec);
        end
        lim = 0;
        while (m_t[0] != 0 && lim < 30) begin cycle(); lim++; end
        cycle();
        n_cmp++;
        if (lim >= 30 || {hour, min, sec, msec} !== 24'd0 || o_run[0] !== 1'b1) begin
            n_err++; $display("FAIL rollover: got %h run=%b want 0 run=1", {hour, min, sec, msec}, o_run[0]);
        end
    endtask

    task automatic test_countdown();
        int lim;
        bit seen;
        ch_sel = 2'd1; i_field = 2'd0;
        pulse(3); pulse(3);
        pulse(2);
        pulse(0);
        n_cmp++;
        if (o_dir[1] !== 1'b1 || o_run[1] !== 1'b1) begin
            n_err++; $display("FAIL down_start: got dir=%b run=%b want 1 1", o_dir[1], o_run[1]);
        end
        lim = 0; seen = 0;
        while (!seen && lim < 2500) begin
            cycle(); lim++;
            n_cmp++;
            if (o_done !== e_done) begin
                n_err++; $display("FAIL done_track: got %b want %b", o_done, e_done);
            end
            if (o_done[1] === 1'b1) seen = 1;
        end
        n_cmp++;
        if (!seen || o_run[1] !== 1'b0) begin
            n_err++; $display("FAIL down_done: got seen=%b run=%b want 1 0", seen, o_run[1]);
        end
        cycle();
        n_cmp++;
        if (o_done[1] !== 1'b0 || {hour, min, sec, msec} !== 24'd0) begin
            n_err++; $display("FAIL done_pulse_len: got done=%b time=%h want 0 0", o_done[1], {hour, min, sec, msec});
        end
        pulse(0);
        for (int k = 0; k < 20; k++) begin
            cycle();
            n_cmp++;
            if (o_run[1] !== 1'b0 || o_done[1] !== 1'b0) begin
                n_err++; $display("FAIL zero_runstop_ignored: got run=%b done=%b want 0 0", o_run[1], o_done[1]);
            end
        end
    endtask

    task automatic test_isolation();
        ch_sel = 2'd2; i_field = 2'd1;
        pulse(3);
        idle(25);
        n_cmp++;
        if ({hour, min, sec, msec} !== {5'd0, 6'd1, 6'd0, 7'd0} || o_run[0] !== 1'b1) begin
            n_err++; $display("FAIL ch2_edit: got %0d:%0d run0=%b want 0:1 run0=1", hour, min, o_run[0]);
        end
        ch_sel = 2'd0;
        cycle();
        n_cmp++;
        if ({hour, min, sec, msec} !== e_disp) begin
            n_err++; $display("FAIL ch0_view: got %h want %h", {hour, min, sec, msec}, e_disp);
        end
    endtask

    task automatic test_clear_priority();
        logic [23:0] snap;
        ch_sel = 2'd0;
        i_clear = 1'b1; i_runstop = 1'b1;
        cycle();
        i_clear = 1'b0; i_runstop = 1'b0;
        cycle();
        n_cmp++;
        if ({hour, min, sec, msec} !== 24'd0 || o_run[0] !== 1'b0) begin
            n_err++; $display("FAIL clear_over_runstop: got %h run=%b want 0 0", {hour, min, sec, msec}, o_run[0]);
        end
        pulse(0);
        idle(15);
        i_field = 2'd0;
        pulse(3);
        cycle();
        snap = e_disp;
        n_cmp++;
        if ({hour, min, sec, msec} !== snap || sec !== 6'd0 || o_run[0] !== 1'b1) begin
            n_err++; $display("FAIL up_in_run: got %h run=%b want %h run=1", {hour, min, sec, msec}, o_run[0], snap);
        end
    endtask

    task automatic test_rst_mid();
        int lim;
        ch_sel = 2'd3; i_field = 2'd0;
        pulse(3);
        pulse(2);
        pulse(0);
        lim = 0;
        while (m_t[3] != 1 && lim < 1200) begin cycle(); lim++; end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_cmp++;
        if (lim >= 1200 || {hour, min, sec, msec, o_run, o_dir, o_done, o_tick} !== 37'd0) begin
            n_err++; $display("FAIL rst_mid: got %h want 0", {hour, min, sec, msec, o_run, o_dir, o_done, o_tick});
        end
        for (int k = 0; k < 40; k++) begin
            cycle();
            n_cmp++;
            if (o_done !== 4'd0) begin
                n_err++; $display("FAIL rst_drops_done: got %b want 0", o_done);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4000; k++) begin
            rst       = ($urandom_range(0, 399) == 0);
            ch_sel    = 2'($urandom_range(0, 3));
            i_field   = 2'($urandom_range(0, 3));
            i_clear   = ($urandom_range(0, 39) == 0);
            i_runstop = ($urandom_range(0, 9) == 0);
            i_mode    = ($urandom_range(0, 7) == 0);
            i_up      = ($urandom_range(0, 4) == 0);
            i_down    = ($urandom_range(0, 4) == 0);
            cycle();
            n_cmp++;
            if ({hour, min, sec, msec} !== e_disp) begin
                n_err++; $display("FAIL rnd_time k=%0d: got %h want %h", k, {hour, min, sec, msec}, e_disp);
            end
            n_cmp++;
            if ({o_run, o_dir, o_done, o_tick} !== {e_run, e_dir, e_done, e_tick}) begin
                n_err++; $display("FAIL rnd_flags k=%0d: got %h want %h", k,
                                  {o_run, o_dir, o_done, o_tick}, {e_run, e_dir, e_done, e_tick});
            end
        end
        {rst, i_runstop, i_clear, i_mode, i_up, i_down} = '0;
    endtask

    initial begin
        #1;
        test_reset();
        test_count_up();
        test_countdown();
        test_isolation();
        test_clear_priority();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
